// File: rtl/prio_dump_scheduler.sv
// -----------------------------------------------------------------------------
// prio_dump_scheduler
//
// Channel-service scheduler for the encoder front end. An arm pulse in IDLE
// captures a request mask. Pending channels are then granted one at a time,
// both as a one-hot vector and as an index. Each dump retires the current
// grant. When nothing is left pending, a single-cycle DONE state pulses
// cycle_done_o and the block returns to IDLE.
//
// Two arbitration modes are available:
//   RR_MODE=0 : fixed priority, where the lowest set index wins.
//   RR_MODE=1 : round-robin. The lowest set index at or above rr_ptr wins,
//               and the search wraps to the lowest set index overall.
//
// Ports:
//   clk_i          rising-edge clock
//   resetn_i       asynchronous active-low reset
//   ch_sel_i       request mask, sampled while arm_i=1
//   arm_i          start a cycle (IDLE) / merge late requests (SERVE)
//   dump_i         current grant consumed; retire it
//   abort_i        cancel the cycle and return to IDLE (highest priority)
//   ch_sel_o       one-hot grant, zero when valid_o=0
//   grant_idx_o    index of the granted channel, zero when valid_o=0
//   valid_o        a grant is being presented
//   zero_o         pending mask is empty
//   cycle_done_o   one-cycle pulse after the last retirement
//   busy_o         state is not IDLE
//   served_cnt_o   grants retired in this cycle (saturates at N_CH)
// -----------------------------------------------------------------------------
module prio_dump_scheduler #(
  parameter int N_CH    = 16,
  parameter int RR_MODE = 0,
  parameter int IDX_W   = $clog2(N_CH),
  parameter int CNT_W   = $clog2(N_CH + 1)
) (
  input  logic              clk_i,
  input  logic              resetn_i,
  input  logic [N_CH-1:0]   ch_sel_i,
  input  logic              arm_i,
  input  logic              dump_i,
  input  logic              abort_i,
  output logic [N_CH-1:0]   ch_sel_o,
  output logic [IDX_W-1:0]  grant_idx_o,
  output logic              valid_o,
  output logic              zero_o,
  output logic              cycle_done_o,
  output logic              busy_o,
  output logic [CNT_W-1:0]  served_cnt_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SERVE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(N_CH);

  state_t             state_reg, state_next;
  logic [N_CH-1:0]    pending_reg, pending_next;
  logic [IDX_W-1:0]   rr_ptr_reg, rr_ptr_next;
  logic [CNT_W-1:0]   served_cnt_reg, served_cnt_next;

  logic [N_CH-1:0]    elig_hi;      // pending channels at or above rr_ptr
  logic [N_CH-1:0]    grant_oh;
  logic [IDX_W-1:0]   grant_idx;
  logic               grant_valid;
  logic [N_CH-1:0]    retire_mask;
  logic [N_CH-1:0]    merge_mask;

  // Returns the index of the lowest set bit. The scan runs downward so that
  // the last assignment is the lowest index.
  function automatic logic [IDX_W-1:0] lowest_idx(input logic [N_CH-1:0] m);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (m[i]) r = IDX_W'(i);
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Grant selection. This logic is purely combinational from the registered
  // state, so a change in pending shows up at the grant outputs in the same
  // cycle.
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_elig
      localparam logic [IDX_W-1:0] GI_IDX = IDX_W'(gi);
      assign elig_hi[gi] = pending_reg[gi] && (GI_IDX >= rr_ptr_reg);
    end
  endgenerate

  assign grant_valid = (state_reg == S_SERVE) && (pending_reg != '0);

  always_comb begin
    grant_idx = lowest_idx(pending_reg);
    // In round-robin mode, prefer channels at or above the pointer. When none
    // exist, fall back to the plain lowest index, which gives the wrap-around.
    if (RR_MODE == 1 && elig_hi != '0) begin
      grant_idx = lowest_idx(elig_hi);
    end
  end

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_onehot
      localparam logic [IDX_W-1:0] GI_IDX = IDX_W'(gi);
      assign grant_oh[gi] = grant_valid && (grant_idx == GI_IDX);
    end
  endgenerate

  assign retire_mask = dump_i ? grant_oh : '0;
  assign merge_mask  = arm_i ? ch_sel_i : '0;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next      = state_reg;
    pending_next    = pending_reg;
    rr_ptr_next     = rr_ptr_reg;
    served_cnt_next = served_cnt_reg;

    if (abort_i) begin
      // An abort drops all pending work. The counter and rr_ptr keep their
      // values so that the next cycle resumes round-robin where it stopped.
      state_next   = S_IDLE;
      pending_next = '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (arm_i) begin
            pending_next    = ch_sel_i;
            served_cnt_next = '0;
            // An empty arm still passes through DONE, so the requester
            // always receives a completion pulse.
            state_next      = (ch_sel_i != '0) ? S_SERVE : S_DONE;
          end
        end

        S_SERVE: begin
          // The set term is applied after the clear term. A channel that is
          // retired and re-requested in the same cycle therefore stays pending.
          pending_next = (pending_reg & ~retire_mask) | merge_mask;
          if (dump_i && grant_valid) begin
            if (served_cnt_reg != CNT_MAX) begin
              served_cnt_next = served_cnt_reg + CNT_W'(1);
            end
            if (RR_MODE == 1) begin
              rr_ptr_next = (grant_idx == LAST_IDX) ? '0 : grant_idx + IDX_W'(1);
            end
          end
          state_next = (pending_next == '0) ? S_DONE : S_SERVE;
        end

        S_DONE: begin
          state_next = S_IDLE;
        end

        default: begin
          state_next   = S_IDLE;
          pending_next = '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_reg      <= S_IDLE;
      pending_reg    <= '0;
      rr_ptr_reg     <= '0;
      served_cnt_reg <= '0;
    end else begin
      state_reg      <= state_next;
      pending_reg    <= pending_next;
      rr_ptr_reg     <= rr_ptr_next;
      served_cnt_reg <= served_cnt_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign ch_sel_o     = grant_oh;
  assign grant_idx_o  = grant_valid ? grant_idx : '0;
  assign valid_o      = grant_valid;
  assign zero_o       = (pending_reg == '0);
  assign cycle_done_o = (state_reg == S_DONE);
  assign busy_o       = (state_reg != S_IDLE);
  assign served_cnt_o = served_cnt_reg;

endmodule

// File: tb/tb_prio_dump_scheduler.sv
// -----------------------------------------------------------------------------
// tb_prio_dump_scheduler
//
// Three instances share one clock and one reset:
//   d=0 : N_CH=16, fixed priority
//   d=1 : N_CH=16, round-robin
//   d=2 : N_CH=5,  round-robin
// Each instance has its own stimulus. A reference arbiter predicts every
// grant. The prediction is queued when a dump is driven and is popped
// against the DUT's presented grant.
// -----------------------------------------------------------------------------
module tb_prio_dump_scheduler;

  logic clk_i = 1'b0;
  logic resetn_i;
  always #5 clk_i = ~clk_i;

  logic [15:0] sel     [3];
  logic        arm_s   [3];
  logic        dump_s  [3];
  logic        abort_s [3];

  logic [15:0] cso   [3];
  logic [3:0]  gidx  [3];
  logic        vld   [3];
  logic        zer   [3];
  logic        dne   [3];
  logic        bsy   [3];
  logic [4:0]  cnt   [3];

  logic [15:0] a_cso; logic [3:0] a_gidx; logic a_v, a_z, a_d, a_b; logic [4:0] a_cnt;
  logic [15:0] b_cso; logic [3:0] b_gidx; logic b_v, b_z, b_d, b_b; logic [4:0] b_cnt;
  logic [4:0]  c_cso; logic [2:0] c_gidx; logic c_v, c_z, c_d, c_b; logic [2:0] c_cnt;

  prio_dump_scheduler #(.N_CH(16), .RR_MODE(0)) u_a (
    .clk_i(clk_i), .resetn_i(resetn_i), .ch_sel_i(sel[0]), .arm_i(arm_s[0]),
    .dump_i(dump_s[0]), .abort_i(abort_s[0]), .ch_sel_o(a_cso), .grant_idx_o(a_gidx),
    .valid_o(a_v), .zero_o(a_z), .cycle_done_o(a_d), .busy_o(a_b), .served_cnt_o(a_cnt));

  prio_dump_scheduler #(.N_CH(16), .RR_MODE(1)) u_b (
    .clk_i(clk_i), .resetn_i(resetn_i), .ch_sel_i(sel[1]), .arm_i(arm_s[1]),
    .dump_i(dump_s[1]), .abort_i(abort_s[1]), .ch_sel_o(b_cso), .grant_idx_o(b_gidx),
    .valid_o(b_v), .zero_o(b_z), .cycle_done_o(b_d), .busy_o(b_b), .served_cnt_o(b_cnt));

  prio_dump_scheduler #(.N_CH(5), .RR_MODE(1)) u_c (
    .clk_i(clk_i), .resetn_i(resetn_i), .ch_sel_i(sel[2][4:0]), .arm_i(arm_s[2]),
    .dump_i(dump_s[2]), .abort_i(abort_s[2]), .ch_sel_o(c_cso), .grant_idx_o(c_gidx),
    .valid_o(c_v), .zero_o(c_z), .cycle_done_o(c_d), .busy_o(c_b), .served_cnt_o(c_cnt));

  assign cso[0] = a_cso;            assign cso[1] = b_cso;            assign cso[2] = {11'd0, c_cso};
  assign gidx[0] = a_gidx;          assign gidx[1] = b_gidx;          assign gidx[2] = {1'b0, c_gidx};
  assign vld[0] = a_v;              assign vld[1] = b_v;              assign vld[2] = c_v;
  assign zer[0] = a_z;              assign zer[1] = b_z;              assign zer[2] = c_z;
  assign dne[0] = a_d;              assign dne[1] = b_d;              assign dne[2] = c_d;
  assign bsy[0] = a_b;              assign bsy[1] = b_b;              assign bsy[2] = c_b;
  assign cnt[0] = a_cnt;            assign cnt[1] = b_cnt;            assign cnt[2] = {2'd0, c_cnt};

  // Reference model state
  int          n_ch [3] = '{16, 16, 5};
  bit          rr   [3] = '{1'b0, 1'b1, 1'b1};
  logic [15:0] mpend[3];
  int          mptr [3];
  int          mcnt [3];
  int          sb_q [$];

  int tests_run = 0;
  int tests_failed = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic int ref_grant(input int d);
    if (rr[d]) begin
      for (int i = mptr[d]; i < n_ch[d]; i++) if (mpend[d][i]) return i;
    end
    for (int i = 0; i < n_ch[d]; i++) if (mpend[d][i]) return i;
    return -1;
  endfunction

  task automatic chk_reset_vals(input int d, input string tag);
    chk({tag, "_ch_sel"}, 32'(cso[d]), 32'd0);
    chk({tag, "_gidx"},   32'(gidx[d]), 32'd0);
    chk({tag, "_valid"},  32'(vld[d]), 32'd0);
    chk({tag, "_zero"},   32'(zer[d]), 32'd1);
    chk({tag, "_done"},   32'(dne[d]), 32'd0);
    chk({tag, "_busy"},   32'(bsy[d]), 32'd0);
    chk({tag, "_cnt"},    32'(cnt[d]), 32'd0);
  endtask

  task automatic do_arm(input int d, input logic [15:0] m);
    sel[d] = m; arm_s[d] = 1'b1;
    tick();
    arm_s[d] = 1'b0; sel[d] = '0;
    mpend[d] = m; mcnt[d] = 0;
    chk("arm_busy", 32'(bsy[d]), 32'd1);
    chk("arm_zero", 32'(zer[d]), 32'(m == 16'd0));
    $display("[TB] d%0d arm mask=%h", d, m);
  endtask

  // Retires the current grant. If want>=0, that index is queued as the
  // expected grant; otherwise the reference model's choice is queued.
  // Optionally merges a late request mask in the same cycle.
  task automatic do_dump(input int d, input int want, input bit merge, input logic [15:0] m);
    int g, e;
    logic [15:0] oh;
    g = ref_grant(d);
    sb_q.push_back((want >= 0) ? want : g);
    e  = sb_q.pop_front();
    oh = 16'h0001 << e;
    chk("grant_valid", 32'(vld[d]), 32'd1);
    chk("grant_idx",   32'(gidx[d]), 32'(e));
    chk("grant_oh",    32'(cso[d]), 32'(oh));
    $display("[TB] d%0d dump grant_idx=%0d expected=%0d", d, gidx[d], e);
    dump_s[d] = 1'b1;
    if (merge) begin arm_s[d] = 1'b1; sel[d] = m; end
    tick();
    dump_s[d] = 1'b0; arm_s[d] = 1'b0; sel[d] = '0;
    if (g >= 0) begin
      mpend[d][g] = 1'b0;
      if (mcnt[d] < n_ch[d]) mcnt[d]++;
      if (rr[d]) mptr[d] = (g + 1) % n_ch[d];
    end
    if (merge) mpend[d] = mpend[d] | m;
    chk("served_cnt", 32'(cnt[d]), 32'(mcnt[d]));
    chk("done_pulse", 32'(dne[d]), 32'(mpend[d] == 16'd0));
  endtask

  task automatic expect_idle(input int d);
    tick();
    chk("idle_busy", 32'(bsy[d]), 32'd0);
    chk("idle_done", 32'(dne[d]), 32'd0);
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      sel[d] = '0; arm_s[d] = 1'b0; dump_s[d] = 1'b0; abort_s[d] = 1'b0;
      mpend[d] = '0; mptr[d] = 0; mcnt[d] = 0;
    end
    resetn_i = 1'b0;
    tick(); tick();
    for (int d = 0; d < 3; d++) chk_reset_vals(d, "reset");
    resetn_i = 1'b1;
    tick();

    // 1. Empty arm still completes through DONE
    do_arm(0, 16'h0000);
    chk("empty_done", 32'(dne[0]), 32'd1);
    chk("empty_valid", 32'(vld[0]), 32'd0);
    expect_idle(0);
    chk("empty_cnt", 32'(cnt[0]), 32'd0);

    // 2. Fixed priority, dump every cycle
    do_arm(0, 16'h8421);
    do_dump(0, 0, 1'b0, '0);
    do_dump(0, 5, 1'b0, '0);
    do_dump(0, 10, 1'b0, '0);
    do_dump(0, 15, 1'b0, '0);
    chk("fp_cnt4", 32'(cnt[0]), 32'd4);
    expect_idle(0);

    // 3. Round-robin: abort after two dumps, then resume at the pointer
    do_arm(1, 16'h000F);
    do_dump(1, 0, 1'b0, '0);
    do_dump(1, 1, 1'b0, '0);
    abort_s[1] = 1'b1;
    tick();
    abort_s[1] = 1'b0;
    mpend[1] = '0;
    chk("abort_busy", 32'(bsy[1]), 32'd0);
    chk("abort_done", 32'(dne[1]), 32'd0);
    chk("abort_zero", 32'(zer[1]), 32'd1);
    chk("abort_cnt_hold", 32'(cnt[1]), 32'd2);
    expect_idle(1);
    do_arm(1, 16'h000F);
    do_dump(1, 2, 1'b0, '0);
    do_dump(1, 3, 1'b0, '0);
    do_dump(1, 0, 1'b0, '0);
    do_dump(1, 1, 1'b0, '0);
    expect_idle(1);

    // 4. Late merge in the same cycle as a dump; the re-requested bit stays
    do_arm(0, 16'h0010);
    do_dump(0, 4, 1'b1, 16'h0011);
    chk("merge_busy", 32'(bsy[0]), 32'd1);
    do_dump(0, 0, 1'b0, '0);
    do_dump(0, 4, 1'b0, '0);
    chk("merge_cnt3", 32'(cnt[0]), 32'd3);
    expect_idle(0);

    // 5. Asynchronous reset in the middle of SERVE
    do_arm(0, 16'h00F0);
    do_dump(0, 4, 1'b0, '0);
    #3;
    resetn_i = 1'b0;
    #1;
    chk_reset_vals(0, "async_rst");
    tick();
    chk("rst_no_done", 32'(dne[0]), 32'd0);
    resetn_i = 1'b1;
    for (int d = 0; d < 3; d++) begin mpend[d] = '0; mptr[d] = 0; mcnt[d] = 0; end
    tick();
    chk("post_rst_busy", 32'(bsy[0]), 32'd0);

    // 6. Five-channel round-robin wrap from rr_ptr=4
    do_arm(2, 16'h0008);
    do_dump(2, 3, 1'b0, '0);
    expect_idle(2);
    do_arm(2, 16'h0011);
    do_dump(2, 4, 1'b0, '0);
    do_dump(2, 0, 1'b0, '0);
    chk("n5_cnt2", 32'(cnt[2]), 32'd2);
    expect_idle(2);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
